// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with ROB rename tags and operand bypass
//
// Purpose: 32 x {value, busy, tag} register file for an out-of-order core.
//   Reads are combinational and resolve each source operand from the
//   committed value, a same-cycle commit, or the ROB result bus. Commits
//   write values; renames mark registers busy with the producing ROB tag.
//
// Ports:
//   clockIn, resetIn                      clock, synchronous active-high reset
//   clear                                 mispredict flush (drops all busy bits)
//   regUpdateValid/Dest/RobId, regValue   ROB commit
//   renameValid/Dest/RobId                issue-time rename of a destination
//   rs1, rs2                              source register indices
//   rs1Dep, rs2Dep                        ROB tag looked up for each source
//   rs1Ready/Value, rs2Ready/Value        ROB answer for rsNDep
//   op1Valid/Value/Tag, op2Valid/Value/Tag  resolved operands
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clear,
  input  logic                 regUpdateValid,
  input  logic [4:0]           regUpdateDest,
  input  logic [31:0]          regValue,
  input  logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic                 renameValid,
  input  logic [4:0]           renameDest,
  input  logic [ROB_WIDTH-1:0] renameRobId,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [ROB_WIDTH-1:0] rs1Dep,
  output logic [ROB_WIDTH-1:0] rs2Dep,
  input  logic                 rs1Ready,
  input  logic                 rs2Ready,
  input  logic [31:0]          rs1Value,
  input  logic [31:0]          rs2Value,
  output logic                 op1Valid,
  output logic                 op2Valid,
  output logic [31:0]          op1Value,
  output logic [31:0]          op2Value,
  output logic [ROB_WIDTH-1:0] op1Tag,
  output logic [ROB_WIDTH-1:0] op2Tag
);

  logic [31:0]          value_q [32];
  logic                 busy_q  [32];
  logic [ROB_WIDTH-1:0] tag_q   [32];

  // One-hot per-register write enables; x0 is never selected.
  logic [31:0] commit_sel;
  logic [31:0] rename_sel;
  logic [31:0] retire_sel;

  always_comb begin
    commit_sel = '0;
    rename_sel = '0;
    retire_sel = '0;
    if (regUpdateValid && (regUpdateDest != 5'd0))
      commit_sel[regUpdateDest] = 1'b1;
    if (renameValid && !clear && (renameDest != 5'd0))
      rename_sel[renameDest] = 1'b1;
    // A commit only frees the register if it is the newest producer.
    for (int i = 1; i < 32; i++)
      retire_sel[i] = commit_sel[i] && (tag_q[i] == regUpdateRobId);
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (commit_sel[i])
          value_q[i] <= regValue;
        // Flush beats rename; rename beats a same-cycle retire of that register.
        if (clear) begin
          busy_q[i] <= 1'b0;
        end else if (rename_sel[i]) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= renameRobId;
        end else if (retire_sel[i]) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  function automatic void resolve(
    input  logic [4:0]           rs,
    input  logic                 rob_ready,
    input  logic [31:0]          rob_value,
    output logic                 valid,
    output logic [31:0]          value
  );
    valid = 1'b0;
    value = '0;
    if (rs == 5'd0) begin
      valid = 1'b1;
    end else if (!busy_q[rs]) begin
      valid = 1'b1;
      value = value_q[rs];
    end else if (regUpdateValid && (regUpdateDest == rs) && (regUpdateRobId == tag_q[rs])) begin
      valid = 1'b1;
      value = regValue;
    end else if (rob_ready) begin
      valid = 1'b1;
      value = rob_value;
    end
  endfunction

  always_comb begin
    rs1Dep = tag_q[rs1];
    rs2Dep = tag_q[rs2];
    resolve(rs1, rs1Ready, rs1Value, op1Valid, op1Value);
    resolve(rs2, rs2Ready, rs2Value, op2Valid, op2Value);
    // Storage may be uninitialised while reset is first held; present clean operands.
    if (resetIn) begin
      rs1Dep   = '0;
      rs2Dep   = '0;
      op1Valid = 1'b1;
      op2Valid = 1'b1;
      op1Value = '0;
      op2Value = '0;
    end
    op1Tag = rs1Dep;
    op2Tag = rs2Dep;
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized bench for register_file against a reference model
module tb_register_file;

  logic        clockIn = 1'b0;
  logic        resetIn, clear;
  logic        regUpdateValid;
  logic [4:0]  regUpdateDest;
  logic [31:0] regValue;
  logic [3:0]  regUpdateRobId;
  logic        renameValid;
  logic [4:0]  renameDest;
  logic [3:0]  renameRobId;
  logic [4:0]  rs1, rs2;
  logic [3:0]  rs1Dep, rs2Dep;
  logic        rs1Ready, rs2Ready;
  logic [31:0] rs1Value, rs2Value;
  logic        op1Valid, op2Valid;
  logic [31:0] op1Value, op2Value;
  logic [3:0]  op1Tag, op2Tag;

  always #5 clockIn = ~clockIn;

  register_file #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regValue(regValue), .regUpdateRobId(regUpdateRobId),
    .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId),
    .rs1(rs1), .rs2(rs2), .rs1Dep(rs1Dep), .rs2Dep(rs2Dep),
    .rs1Ready(rs1Ready), .rs2Ready(rs2Ready), .rs1Value(rs1Value), .rs2Value(rs2Value),
    .op1Valid(op1Valid), .op2Valid(op2Valid), .op1Value(op1Value), .op2Value(op2Value),
    .op1Tag(op1Tag), .op2Tag(op2Tag)
  );

  int vectors = 0;
  int miscompares = 0;

  // Architectural model: what each register holds, whether a rename is outstanding, and who produces it.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic void expect_op(input logic [4:0] rs, input logic rdy, input logic [31:0] rv,
                                    output logic v, output logic [31:0] val, output logic [3:0] dep);
    v = 1'b0; val = '0; dep = '0;
    if (resetIn) begin
      v = 1'b1;
    end else begin
      dep = (rs == 0) ? 4'd0 : m_tag[rs];
      if (rs == 0)                         v = 1'b1;
      else if (!m_busy[rs])                begin v = 1'b1; val = m_val[rs]; end
      else if (regUpdateValid && regUpdateDest == rs && regUpdateRobId == m_tag[rs])
                                           begin v = 1'b1; val = regValue; end
      else if (rdy)                        begin v = 1'b1; val = rv; end
    end
  endfunction

  task automatic model_check();
    logic v; logic [31:0] val; logic [3:0] dep;
    expect_op(rs1, rs1Ready, rs1Value, v, val, dep);
    check("op1_valid", 32'(op1Valid), 32'(v));
    if (v) check("op1_value", op1Value, val);
    else   check("op1_tag", 32'(op1Tag), 32'(dep));
    check("rs1_dep", 32'(rs1Dep), 32'(dep));
    expect_op(rs2, rs2Ready, rs2Value, v, val, dep);
    check("op2_valid", 32'(op2Valid), 32'(v));
    if (v) check("op2_value", op2Value, val);
    else   check("op2_tag", 32'(op2Tag), 32'(dep));
    check("rs2_dep", 32'(rs2Dep), 32'(dep));
  endtask

  task automatic model_update();
    logic frees;
    if (resetIn) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else begin
      frees = regUpdateValid && regUpdateDest != 0 && m_tag[regUpdateDest] == regUpdateRobId;
      if (regUpdateValid && regUpdateDest != 0) m_val[regUpdateDest] = regValue;
      if (clear) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (frees) m_busy[regUpdateDest] = 0;
        if (renameValid && renameDest != 0) begin
          m_busy[renameDest] = 1;
          m_tag[renameDest]  = renameRobId;
        end
      end
    end
  endtask

  task automatic step();
    #1 model_check();
    @(posedge clockIn);
    model_update();
    @(negedge clockIn);
  endtask

  task automatic idle();
    resetIn = 0; clear = 0;
    regUpdateValid = 0; regUpdateDest = 0; regValue = 0; regUpdateRobId = 0;
    renameValid = 0; renameDest = 0; renameRobId = 0;
    rs1 = 0; rs2 = 0; rs1Ready = 0; rs2Ready = 0; rs1Value = 0; rs2Value = 0;
  endtask

  task automatic rename(input logic [4:0] d, input logic [3:0] id);
    idle(); renameValid = 1; renameDest = d; renameRobId = id; step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    idle();
    @(negedge clockIn);
    resetIn = 1; rs1 = 5; rs2 = 9;
    #1 check("rst_op1_valid", 32'(op1Valid), 1); check("rst_op1_value", op1Value, 0);
    check("rst_rs1_dep", 32'(rs1Dep), 0);
    step(); step();

    // First cycle after reset: x5 and x0 both valid zero.
    idle(); rs1 = 5; rs2 = 0;
    #1 check("post_rst_op1_valid", 32'(op1Valid), 1); check("post_rst_op1_value", op1Value, 0);
    check("post_rst_op2_valid", 32'(op2Valid), 1); check("post_rst_op2_value", op2Value, 0);
    step();

    // Rename then ROB bypass.
    rename(5, 3);
    idle(); rs1 = 5;
    #1 check("dep_op1_valid", 32'(op1Valid), 0); check("dep_op1_tag", 32'(op1Tag), 3);
    check("dep_rs1_dep", 32'(rs1Dep), 3);
    step();
    idle(); rs1 = 5; rs1Ready = 1; rs1Value = 77;
    #1 check("rob_bypass", op1Value, 77); check("rob_bypass_valid", 32'(op1Valid), 1);
    step();

    // Commit bypass, then the retired value.
    idle(); rs1 = 5; regUpdateValid = 1; regUpdateDest = 5; regUpdateRobId = 3; regValue = 42;
    #1 check("commit_bypass", op1Value, 42);
    step();
    idle(); rs1 = 5;
    #1 check("retired_valid", 32'(op1Valid), 1); check("retired_value", op1Value, 42);
    step();

    // Stale commit keeps the newer producer; commit+rename of same register keeps it busy.
    rename(5, 3);
    rename(5, 7);
    idle(); regUpdateValid = 1; regUpdateDest = 5; regUpdateRobId = 3; regValue = 9; step();
    idle(); rs1 = 5;
    #1 check("stale_commit_busy", 32'(op1Valid), 0); check("stale_commit_tag", 32'(op1Tag), 7);
    step();
    idle(); regUpdateValid = 1; regUpdateDest = 5; regUpdateRobId = 7; regValue = 1;
    renameValid = 1; renameDest = 5; renameRobId = 2; step();
    idle(); rs1 = 5;
    #1 check("rename_wins_busy", 32'(op1Valid), 0); check("rename_wins_tag", 32'(op1Tag), 2);
    step();

    // Flush: rename dropped, commit value kept.
    rename(1, 1); rename(2, 2); rename(3, 3);
    idle(); clear = 1; renameValid = 1; renameDest = 4; renameRobId = 5;
    regUpdateValid = 1; regUpdateDest = 1; regUpdateRobId = 1; regValue = 11; step();
    idle(); rs1 = 1; rs2 = 4;
    #1 check("flush_x1", op1Value, 11); check("flush_x1_valid", 32'(op1Valid), 1);
    check("flush_x4_valid", 32'(op2Valid), 1);
    step();
    idle(); rs1 = 2; rs2 = 3;
    #1 check("flush_x2_valid", 32'(op1Valid), 1); check("flush_x3_valid", 32'(op2Valid), 1);
    step();

    // x0 is immutable.
    idle(); regUpdateValid = 1; regUpdateDest = 0; regValue = 123; regUpdateRobId = 6;
    renameValid = 1; renameDest = 0; renameRobId = 6; step();
    idle(); rs1 = 0;
    #1 check("x0_valid", 32'(op1Valid), 1); check("x0_value", op1Value, 0);
    step();

    // Reset during a rename leaves nothing busy.
    idle(); resetIn = 1; renameValid = 1; renameDest = 6; renameRobId = 4; step();
    idle(); rs1 = 6;
    #1 check("rst_rename_valid", 32'(op1Valid), 1); check("rst_rename_value", op1Value, 0);
    step();

    // Random traffic on a small register window so collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      idle();
      resetIn        = ($urandom_range(0, 99) < 2);
      clear          = ($urandom_range(0, 99) < 5);
      regUpdateValid = $urandom_range(0, 1);
      regUpdateDest  = 5'($urandom_range(0, 7));
      regValue       = $urandom;
      regUpdateRobId = $urandom_range(0, 1) ? m_tag[regUpdateDest] : 4'($urandom_range(0, 15));
      renameValid    = $urandom_range(0, 1);
      renameDest     = 5'($urandom_range(0, 7));
      renameRobId    = 4'($urandom_range(0, 15));
      rs1            = 5'($urandom_range(0, 7));
      rs2            = 5'($urandom_range(0, 7));
      rs1Ready       = $urandom_range(0, 1);
      rs2Ready       = $urandom_range(0, 1);
      rs1Value       = $urandom;
      rs2Value       = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: RegisterFile

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, width of ROB entry tags.
REQ-002 SHALL have clockIn  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have resetIn  input  1  reset, synchronous, active-high.
REQ-004 SHALL have clear  input  1  ROB mispredict flush.
REQ-005 SHALL have regUpdateValid  input  1  ROB commit strobe.
REQ-006 SHALL have regUpdateDest  input  5  commit destination register.
REQ-007 SHALL have regValue  input  32  commit value.
REQ-008 SHALL have regUpdateRobId  input  ROB_WIDTH  committing ROB entry.
REQ-009 SHALL have renameValid  input  1  instruction unit issues an instruction with a destination.
REQ-010 SHALL have renameDest  input  5  issued destination register.
REQ-011 SHALL have renameRobId  input  ROB_WIDTH  ROB entry allocated to it.
REQ-012 SHALL have rs1, rs2  input  5 each  source register indices from the instruction unit.
REQ-013 SHALL have rs1Dep, rs2Dep  output  ROB_WIDTH each  tag queried in the ROB.
REQ-014 SHALL have rs1Ready, rs2Ready  input  1 each  ROB entry for rsNDep is complete.
REQ-015 SHALL have rs1Value, rs2Value  input  32 each  ROB value for rsNDep.
REQ-016 SHALL have op1Valid, op2Valid  output  1 each  operand value is available.
REQ-017 SHALL have op1Value, op2Value  output  32 each  operand value.
REQ-018 SHALL have op1Tag, op2Tag  output  ROB_WIDTH each  producer tag when opNValid=0.

Function
REQ-019 SHALL hold 32 entries of {value[31:0], busy, tag[ROB_WIDTH-1:0]}.
REQ-020 SHALL treat x0 as constant: reads give valid=1, value 0; commits and renames to x0 ignored, never busy.
REQ-021 Read path SHALL be combinational, per source N: rsNDep = tag[rsN] always.
REQ-022 If rsN=0 or not busy[rsN]: opNValid=1, opNValue=value[rsN].
REQ-023 Else if regUpdateValid, regUpdateDest=rsN, regUpdateRobId=tag[rsN]: opNValid=1, opNValue=regValue (commit bypass).
REQ-024 Else if rsNReady: opNValid=1, opNValue=rsNValue (ROB bypass).
REQ-025 Else opNValid=0, opNTag=tag[rsN], opNValue don't-care.
REQ-026 Reads SHALL reflect state before the same-cycle rename (instruction with rd=rs1 sees old mapping).
REQ-027 On commit (regUpdateValid, dest!=0): value[dest]<=regValue next edge, 1-cycle write latency.
REQ-028 On commit, busy[dest]<=0 only if tag[dest]=regUpdateRobId and no same-cycle rename of dest.
REQ-029 On commit with tag mismatch (newer rename outstanding): value written, busy/tag unchanged.
REQ-030 On rename (renameValid, dest!=0, clear=0): busy[dest]<=1, tag[dest]<=renameRobId.
REQ-031 Simultaneous commit and rename of same register: value<=regValue, busy=1, tag=renameRobId (rename wins for busy/tag).
REQ-032 Simultaneous commit and rename of different registers: both applied independently.
REQ-033 On clear: all busy<=0 next edge; same-cycle rename discarded; same-cycle commit value still written.
REQ-034 Tags SHALL compare full ROB_WIDTH bits; wrap-around of ROB indices needs no special handling.

Reset
REQ-035 On resetIn at posedge: all value<=0, busy<=0, tag<=0; precedence over clear, commit, rename.
REQ-036 During and one cycle after reset, outputs SHALL be opNValid=1, opNValue=0, rsNDep=0.
REQ-037 Reset mid-rename SHALL leave no busy register.

Verification
REQ-038 Reset, read rs1=5,rs2=0 -> op1Valid=1 op1Value=0, op2Valid=1 op2Value=0.
REQ-039 Rename x5->tag 3; next cycle rs1=5, rs1Ready=0 -> op1Valid=0, op1Tag=3, rs1Dep=3; rs1Ready=1 rs1Value=77 -> op1Valid=1 op1Value=77.
REQ-040 x5 busy tag 3; commit dest 5 tag 3 value 42 with rs1=5 -> op1Value=42 same cycle; next cycle busy[5]=0, op1Value=42.
REQ-041 Rename x5->3, rename x5->7, commit x5 tag 3 value 9 -> value[5]=9, busy=1, tag=7; same-cycle commit tag 7 + rename tag 2 -> tag=2, busy=1.
REQ-042 x1..x3 busy, assert clear with rename x4->5 and commit x1 value 11 -> next cycle all opNValid=1, x4 not busy, x1 reads 11.
REQ-043 Commit/rename x0 value 123 -> x0 reads 0, valid=1, never busy.
